// File: rtl/neopx_pkg.sv
// Shared constants, state encodings and wire-order helper for the NeoPixel driver.
// NEOPX_RGBW_EN selects 32-bit RGBW pixels; otherwise 24-bit RGB.
package neopx_pkg;

    localparam int unsigned NUM_PIXELS_DEF = 64;
    localparam int unsigned T_BIT_DEF      = 90;
    localparam int unsigned T0H_DEF        = 25;
    localparam int unsigned T1H_DEF        = 50;
    localparam int unsigned T_RST_DEF      = 21600;

`ifdef NEOPX_RGBW_EN
    localparam int unsigned BPP = 32;
`else
    localparam int unsigned BPP = 24;
`endif

    // Word offsets on adr[8:2]
    localparam logic [6:0] REG_CTRL  = 7'h00;
    localparam logic [6:0] REG_COUNT = 7'h01;
    localparam logic [6:0] PIX_BASE  = 7'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } neopx_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_HIGH,
        PH_LOW
    } neopx_phase_e;

    // Stored word (0x[WW]RRGGBB) to transmit order G, R, B[, W], MSB first
    function automatic logic [BPP-1:0] wire_order(input logic [BPP-1:0] w);
`ifdef NEOPX_RGBW_EN
        return {w[15:8], w[23:16], w[7:0], w[31:24]};
`else
        return {w[15:8], w[23:16], w[7:0]};
`endif
    endfunction

endpackage

// File: rtl/neopx_bit_serializer.sv
// Cycle-exact WS2812 bit encoder: one bit per T_BIT period, high for T0H/T1H.
// bit_req_c is high while a new bit may be accepted; bits are back to back.
module neopx_bit_serializer
    import neopx_pkg::*;
#(
    parameter int unsigned T_BIT = T_BIT_DEF,
    parameter int unsigned T0H   = T0H_DEF,
    parameter int unsigned T1H   = T1H_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_valid,
    input  logic bit_in,
    output logic bit_req_c,
    output logic line
);

    localparam int unsigned CW = $clog2(T_BIT + 1);

    neopx_phase_e   phase, phase_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           cur_bit, cur_bit_nxt;
    logic           line_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= PH_IDLE;
            cnt     <= '0;
            cur_bit <= 1'b0;
            line    <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            cnt     <= cnt_nxt;
            cur_bit <= cur_bit_nxt;
            line    <= line_nxt;
        end
    end

    // cnt numbers the cycles of the current period from 1 to T_BIT
    always_comb begin
        phase_nxt   = phase;
        cnt_nxt     = cnt + CW'(1);
        cur_bit_nxt = cur_bit;
        line_nxt    = line;
        bit_req_c   = 1'b0;
        case (phase)
            PH_IDLE: begin
                bit_req_c = 1'b1;
                cnt_nxt   = '0;
                line_nxt  = 1'b0;
                if (bit_valid) begin
                    phase_nxt   = PH_HIGH;
                    cnt_nxt     = CW'(1);
                    cur_bit_nxt = bit_in;
                    line_nxt    = 1'b1;
                end
            end
            PH_HIGH: begin
                if (cnt == (cur_bit ? CW'(T1H) : CW'(T0H))) begin
                    phase_nxt = PH_LOW;
                    line_nxt  = 1'b0;
                end
            end
            PH_LOW: begin
                if (cnt == CW'(T_BIT)) begin
                    bit_req_c = 1'b1;
                    if (bit_valid) begin
                        phase_nxt   = PH_HIGH;
                        cnt_nxt     = CW'(1);
                        cur_bit_nxt = bit_in;
                        line_nxt    = 1'b1;
                    end else begin
                        phase_nxt = PH_IDLE;
                        cnt_nxt   = '0;
                        line_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                phase_nxt = PH_IDLE;
                cnt_nxt   = '0;
                line_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_neopixel.sv
// Wishbone classic slave with a pixel buffer that streams frames to a NeoPixel chain.
// NEOPX_RGBW_EN switches to 32-bit RGBW pixels.
module wb_neopixel
    import neopx_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int unsigned T_BIT      = T_BIT_DEF,
    parameter int unsigned T0H        = T0H_DEF,
    parameter int unsigned T1H        = T1H_DEF,
    parameter int unsigned T_RST      = T_RST_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_neoPx,
    output logic        o_busy
);

    localparam int unsigned PIX_AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int unsigned GAP_W  = $clog2(T_RST + 1);
    localparam int unsigned BIT_W  = $clog2(BPP);
    localparam int unsigned NBYTES = BPP / 8;

    neopx_state_e      state, state_nxt;
    logic [BPP-1:0]    pix_mem [NUM_PIXELS];
    logic [6:0]        count;
    logic [BPP-1:0]    shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [PIX_AW-1:0] pix_idx;
    logic [6:0]        pix_rem;
    logic [GAP_W-1:0]  gap_cnt;

    logic              wb_acc_c, pix_ok_c, pix_we_c, start_c;
    logic [6:0]        word_adr_c, frame_len_c;
    logic [PIX_AW-1:0] pix_adr_c;
    logic [31:0]       rd_c;
    logic [BPP-1:0]    first_word_c, next_word_c;
    logic              ser_req_c, ser_valid_c, ser_bit_c;
    logic              load_c, adv_bit_c, adv_pix_c;
    logic              unused_c;

    assign unused_c = ^{i_wb_adr, i_wb_dat, i_wb_sel};

    assign wb_acc_c    = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign word_adr_c  = i_wb_adr[8:2];
    assign pix_adr_c   = i_wb_adr[2 +: PIX_AW];
    assign pix_ok_c    = i_wb_adr[8] && ({1'b0, i_wb_adr[7:2]} < 7'(NUM_PIXELS));
    assign pix_we_c    = wb_acc_c & i_wb_we & pix_ok_c;
    assign start_c     = wb_acc_c & i_wb_we & (word_adr_c == REG_CTRL) & i_wb_dat[0] & (count != '0);
    assign frame_len_c = (count > 7'(NUM_PIXELS)) ? 7'(NUM_PIXELS) : count;

    // Next pixel is read at the end of the current pixel's last bit, so late writes still land
    assign first_word_c = wire_order(pix_mem[0]);
    assign next_word_c  = wire_order(pix_mem[PIX_AW'(pix_idx + PIX_AW'(1))]);

    always_comb begin
        rd_c = '0;
        if (pix_ok_c) begin
            rd_c = 32'(pix_mem[pix_adr_c]);
        end else if (word_adr_c == REG_CTRL) begin
            rd_c = {31'd0, o_busy};
        end else if (word_adr_c == REG_COUNT) begin
            rd_c = {25'd0, count};
        end
    end

    // Pixel buffer keeps its contents across reset
    always_ff @(posedge i_clk) begin
        if (pix_we_c) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_wb_sel[b]) begin
                    pix_mem[pix_adr_c][8*b +: 8] <= i_wb_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_ack <= 1'b0;
            o_wb_dat <= '0;
            count    <= '0;
        end else begin
            o_wb_ack <= wb_acc_c;
            o_wb_dat <= (wb_acc_c && !i_wb_we) ? rd_c : '0;
            if (wb_acc_c && i_wb_we && (word_adr_c == REG_COUNT)) begin
                count <= i_wb_dat[6:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ser_valid_c = 1'b0;
        ser_bit_c   = shift_reg[BPP-1];
        load_c      = 1'b0;
        adv_bit_c   = 1'b0;
        adv_pix_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_c) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_c      = 1'b1;
                ser_valid_c = 1'b1;
                ser_bit_c   = first_word_c[BPP-1];
                state_nxt   = ST_SEND;
            end
            ST_SEND: begin
                if (ser_req_c) begin
                    if (bit_cnt != '0) begin
                        ser_valid_c = 1'b1;
                        adv_bit_c   = 1'b1;
                    end else if (pix_rem != '0) begin
                        ser_valid_c = 1'b1;
                        ser_bit_c   = next_word_c[BPP-1];
                        adv_pix_c   = 1'b1;
                    end else begin
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(T_RST - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // shift_reg holds the bits of the current pixel not yet handed to the serializer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            pix_idx   <= '0;
            pix_rem   <= '0;
            gap_cnt   <= '0;
            o_busy    <= 1'b0;
        end else begin
            o_busy  <= (state_nxt != ST_IDLE);
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (load_c) begin
                shift_reg <= first_word_c << 1;
                bit_cnt   <= BIT_W'(BPP - 1);
                pix_idx   <= '0;
                pix_rem   <= frame_len_c - 7'd1;
            end else if (adv_bit_c) begin
                shift_reg <= shift_reg << 1;
                bit_cnt   <= bit_cnt - BIT_W'(1);
            end else if (adv_pix_c) begin
                shift_reg <= next_word_c << 1;
                bit_cnt   <= BIT_W'(BPP - 1);
                pix_idx   <= pix_idx + PIX_AW'(1);
                pix_rem   <= pix_rem - 7'd1;
            end
        end
    end

    neopx_bit_serializer #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_ser (
        .clk       (i_clk),
        .rst       (i_rst),
        .bit_valid (ser_valid_c),
        .bit_in    (ser_bit_c),
        .bit_req_c (ser_req_c),
        .line      (o_neoPx)
    );

endmodule
